// File: rtl/interp2_filter.sv
// 2x linear-interpolation upsampler: each accepted sample x[n] emits the
// midpoint (x[n-1]+x[n])>>1 and then x[n] on consecutive cycles.
module interp2_filter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_ce,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  o_ce,
    output logic                  o_overrun,
    output logic [DATA_WIDTH-1:0] o_prev_sample,
    output logic [DATA_WIDTH:0]   o_sum_ff
);

    typedef enum logic [1:0] {
        IDLE,
        MID_OUT,
        SAMP_OUT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sample_q;
    logic [DATA_WIDTH-1:0] prev_eff;
    logic [DATA_WIDTH:0]   sum_next;
    logic                  accept;

    assign o_ready = (state != MID_OUT);
    assign accept  = i_ce && o_ready;

    // o_prev_sample is only refreshed on the edge leaving SAMP_OUT, so a
    // back-to-back sample accepted on that same edge must pair with sample_q.
    assign prev_eff = (state == SAMP_OUT) ? sample_q : o_prev_sample;
    assign sum_next = (DATA_WIDTH+1)'(prev_eff) + (DATA_WIDTH+1)'(data_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sample_q      <= '0;
            data_out      <= '0;
            o_ce          <= 1'b0;
            o_overrun     <= 1'b0;
            o_prev_sample <= '0;
            o_sum_ff      <= '0;
        end else begin
            if (i_ce && !o_ready) begin
                o_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    o_ce <= 1'b0;
                    if (accept) begin
                        o_sum_ff <= sum_next;
                        sample_q <= data_in;
                        state    <= MID_OUT;
                    end
                end
                MID_OUT: begin
                    o_ce     <= 1'b1;
                    data_out <= o_sum_ff[DATA_WIDTH:1];
                    state    <= SAMP_OUT;
                end
                SAMP_OUT: begin
                    o_ce          <= 1'b1;
                    data_out      <= sample_q;
                    o_prev_sample <= sample_q;
                    if (accept) begin
                        o_sum_ff <= sum_next;
                        sample_q <= data_in;
                        state    <= MID_OUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    o_ce  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp2_filter.sv
// Scoreboard bench for interp2_filter: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever o_ce is high.
module tb_interp2_filter;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_ce = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          o_ready;
    logic [DW-1:0] data_out;
    logic          o_ce;
    logic          o_overrun;
    logic [DW-1:0] o_prev_sample;
    logic [DW:0]   o_sum_ff;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    interp2_filter #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_ce          (i_ce),
        .data_in       (data_in),
        .o_ready       (o_ready),
        .data_out      (data_out),
        .o_ce          (o_ce),
        .o_overrun     (o_overrun),
        .o_prev_sample (o_prev_sample),
        .o_sum_ff      (o_sum_ff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the sampling edge.
    task automatic drive(input logic ce, input int d);
        i_ce    = ce;
        data_in = DW'(d);
        @(posedge clk);
        #1;
        i_ce    = 1'b0;
    endtask

    task automatic send(input int d, input int mid);
        exp_q.push_back(mid);
        exp_q.push_back(d);
        drive(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && o_ce) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_o_ce", int'(data_out), -1);
            end else begin
                chk("data_out", int'(data_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk("rst_o_ce", int'(o_ce), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_prev", int'(o_prev_sample), 0);
        chk("rst_sum", int'(o_sum_ff), 0);
        chk("rst_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // first sample interpolates against zero
        send(100, 50);
        chk("mid_ready_low", int'(o_ready), 0);
        chk("sum_100", int'(o_sum_ff), 100);
        idle(3);
        chk("idle_o_ce", int'(o_ce), 0);
        chk("idle_ready", int'(o_ready), 1);
        chk("prev_100", int'(o_prev_sample), 100);

        // gapless stream, odd sum, full-scale and drop to zero
        send(200, 150);
        idle(1);
        send(101, 150);
        idle(1);
        send(255, 178);
        idle(1);
        send(255, 255);
        chk("sum_510", int'(o_sum_ff), 510);
        idle(1);
        send(0, 127);
        chk("overrun_clear", int'(o_overrun), 0);
        idle(3);
        chk("prev_0", int'(o_prev_sample), 0);

        // overrun: 77 arrives during MID_OUT and must be dropped
        send(40, 20);
        drive(1'b1, 77);
        idle(3);
        chk("overrun_set", int'(o_overrun), 1);
        chk("prev_40", int'(o_prev_sample), 40);

        // i_ce held high: every other strobe dropped
        send(10, 25);
        drive(1'b1, 99);
        send(20, 15);
        idle(3);
        chk("prev_20", int'(o_prev_sample), 20);
        idle(4);
        chk("overrun_sticky", int'(o_overrun), 1);

        // reset during MID_OUT; the pending 90 is lost
        drive(1'b1, 90);
        chk("pre_rst_ready", int'(o_ready), 0);
        reset_n = 1'b0;
        #1;
        chk("mrst_o_ce", int'(o_ce), 0);
        chk("mrst_data_out", int'(data_out), 0);
        chk("mrst_overrun", int'(o_overrun), 0);
        chk("mrst_prev", int'(o_prev_sample), 0);
        chk("mrst_sum", int'(o_sum_ff), 0);
        chk("mrst_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        send(60, 30);
        idle(3);
        chk("prev_60", int'(o_prev_sample), 60);

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
